// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings, controller states and shared helpers for the intersection controller
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        FW_GREEN  = 3'd3,
        FW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;

    // Counter width wide enough for the largest phase-length parameter
    function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        m = (e > m) ? e : m;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic lamp_t hw_lamp(input state_t s);
        return (s == HW_GREEN) ? GREEN : (s == HW_YELLOW) ? YELLOW : RED;
    endfunction

    function automatic lamp_t fw_lamp(input state_t s);
        return (s == FW_GREEN) ? GREEN : (s == FW_YELLOW) ? YELLOW : RED;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: cycles spent in the current phase; clears on phase change, saturates at SAT_CNT
module phase_timer #(
    parameter int W       = 3,
    parameter int SAT_CNT = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] SAT = W'(SAT_CNT);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: restart on a phase change, otherwise count up and hold at the ceiling
    always_comb begin
        cnt_d = clr_i ? '0 : (cnt_q >= SAT) ? cnt_q : cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: highway/farm-road traffic light controller with pedestrian crossing request
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int LONG_CYC   = 8,
    parameter int SHORT_CYC  = 3,
    parameter int ALLRED_CYC = 1,
    parameter int FW_MAX_CYC = 8,
    parameter int PED_CYC    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_on_fw,
    input  logic       ped_req,
    output logic [1:0] hw_light,
    output logic [1:0] fw_light,
    output logic       ped_walk,
    output logic       hw_handover
);

    localparam int CW = cnt_width(LONG_CYC, SHORT_CYC, ALLRED_CYC, FW_MAX_CYC, PED_CYC);
    localparam logic [CW-1:0] LONG_L   = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] SHORT_L  = CW'(SHORT_CYC - 1);
    localparam logic [CW-1:0] ALLRED_L = CW'(ALLRED_CYC - 1);
    localparam logic [CW-1:0] FW_MAX_L = CW'(FW_MAX_CYC - 1);
    localparam logic [CW-1:0] PED_L    = CW'(PED_CYC - 1);

    state_t        state_q, state_d, nxt;
    lamp_t         hw_q, fw_q;
    logic          walk_q;
    logic          ped_pend_q, ped_pend_d;
    logic          ped_mode_q, ped_mode_d;
    logic          go, demand, enter_fw;
    logic [CW-1:0] cnt, fw_min;

    phase_timer #(
        .W       (CW),
        .SAT_CNT (FW_MAX_CYC - 1)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_d != state_q),
        .cnt_o (cnt)
    );

    // Phase-exit condition and successor for the current state
    always_comb begin
        demand = car_on_fw | ped_pend_q;
        fw_min = ped_mode_q ? PED_L : SHORT_L;
        go     = 1'b0;
        nxt    = HW_GREEN;
        case (state_q)
            HW_GREEN: begin
                go  = (cnt >= LONG_L) && demand;
                nxt = HW_YELLOW;
            end
            HW_YELLOW: begin
                go  = (cnt >= SHORT_L);
                nxt = ALLRED_A;
            end
            ALLRED_A: begin
                go  = (cnt >= ALLRED_L);
                nxt = FW_GREEN;
            end
            FW_GREEN: begin
                go  = ((cnt >= fw_min) && !car_on_fw) || (cnt >= FW_MAX_L);
                nxt = FW_YELLOW;
            end
            FW_YELLOW: begin
                go  = (cnt >= SHORT_L);
                nxt = ALLRED_B;
            end
            ALLRED_B: begin
                go  = (cnt >= ALLRED_L);
                nxt = HW_GREEN;
            end
            default: begin
                go  = 1'b1;
                nxt = HW_GREEN;
            end
        endcase
        state_d = go ? nxt : state_q;
    end

    // Pedestrian latch: pending request is consumed as the farm road turns green
    always_comb begin
        enter_fw   = (state_q == ALLRED_A) && go;
        ped_pend_d = enter_fw ? 1'b0 : (ped_req && state_q != FW_GREEN) ? 1'b1 : ped_pend_q;
        ped_mode_d = enter_fw ? (ped_pend_q | ped_req) : ped_mode_q;
    end

    // State, pedestrian flags and lamp registers decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HW_GREEN;
            ped_pend_q <= 1'b0;
            ped_mode_q <= 1'b0;
            hw_q       <= GREEN;
            fw_q       <= RED;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            ped_mode_q <= ped_mode_d;
            hw_q       <= hw_lamp(state_d);
            fw_q       <= fw_lamp(state_d);
            walk_q     <= (state_d == FW_GREEN) && ped_mode_d;
        end
    end

    assign hw_light    = hw_q;
    assign fw_light    = fw_q;
    assign ped_walk    = walk_q;
    assign hw_handover = (state_q == HW_GREEN) && go;

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed timeline tables plus randomized run against a phase-level model
module tb_intersection_ctrl;
    import traffic_pkg::*;

    localparam int LONG = 8, SHORT = 3, ALLRED = 1, FWMAX = 8, PED = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_on_fw = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hw_light, fw_light;
    logic       ped_walk, hw_handover;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    intersection_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .car_on_fw   (car_on_fw),
        .ped_req     (ped_req),
        .hw_light    (hw_light),
        .fw_light    (fw_light),
        .ped_walk    (ped_walk),
        .hw_handover (hw_handover)
    );

    typedef struct {
        string      tag;
        int         n;
        bit         chk;
        bit         car;
        bit         ped;
        bit         rst;
        logic [1:0] hw;
        logic [1:0] fw;
        bit         walk;
        bit         ho;
    } vec_t;

    vec_t tab[$];

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic add(input string tag, input int n, input bit chk, input bit car, input bit ped,
                       input bit rst, input logic [1:0] hw, input logic [1:0] fw, input bit walk, input bit ho);
        vec_t v;
        v.tag = tag; v.n = n; v.chk = chk; v.car = car; v.ped = ped; v.rst = rst;
        v.hw = hw; v.fw = fw; v.walk = walk; v.ho = ho;
        tab.push_back(v);
    endtask

    task automatic start(input string tag);
        add(tag, 1, 0, 0, 0, 1, RED, RED, 0, 0);
    endtask

    // Common prefix: car present through cycle 11 reaches farm green at cycle 12
    task automatic car_to_fw(input string tag);
        add(tag, 7, 1, 1, 0, 0, GREEN, RED, 0, 0);
        add(tag, 1, 1, 1, 0, 0, GREEN, RED, 0, 1);
        add(tag, 3, 1, 1, 0, 0, YELLOW, RED, 0, 0);
        add(tag, 1, 1, 1, 0, 0, RED, RED, 0, 0);
    endtask

    // Phase-level reference model: phase index 0..5 around the cycle, cycles elapsed in phase
    int m_ph, m_t;
    bit m_pend, m_mode;
    int hw_of[6] = '{2, 1, 0, 0, 0, 0};
    int fw_of[6] = '{0, 0, 0, 2, 1, 0};

    function automatic bit m_leave(input bit car);
        int need;
        case (m_ph)
            0: return (m_t >= LONG - 1) && (car || m_pend);
            1, 4: return m_t >= SHORT - 1;
            2, 5: return m_t >= ALLRED - 1;
            default: begin
                need = m_mode ? PED : SHORT;
                return ((m_t >= need - 1) && !car) || (m_t >= FWMAX - 1);
            end
        endcase
    endfunction

    task automatic m_step(input bit car, input bit ped, input bit rst);
        bit lv;
        if (rst) begin
            m_ph = 0; m_t = 0; m_pend = 0; m_mode = 0;
        end else begin
            lv = m_leave(car);
            if (m_ph == 2 && lv) begin
                m_mode = m_pend | ped;
                m_pend = 0;
            end else if (m_ph != 3 && ped) begin
                m_pend = 1;
            end
            m_t  = lv ? 0 : m_t + 1;
            m_ph = lv ? (m_ph + 1) % 6 : m_ph;
        end
    endtask

    bit rc, rp, rr;

    initial begin
        start("idle");
        add("idle", 50, 1, 0, 0, 0, GREEN, RED, 0, 0);

        start("car_const");
        car_to_fw("car_const");
        add("car_const", 8, 1, 1, 0, 0, RED, GREEN, 0, 0);
        add("car_const", 3, 1, 1, 0, 0, RED, YELLOW, 0, 0);
        add("car_const", 1, 1, 1, 0, 0, RED, RED, 0, 0);
        add("car_const", 7, 1, 1, 0, 0, GREEN, RED, 0, 0);
        add("car_const", 1, 1, 1, 0, 0, GREEN, RED, 0, 1);
        add("car_const", 1, 1, 1, 0, 0, YELLOW, RED, 0, 0);

        start("ped_pulse");
        add("ped_pulse", 2, 1, 0, 0, 0, GREEN, RED, 0, 0);
        add("ped_pulse", 1, 1, 1, 1, 0, GREEN, RED, 0, 0);
        add("ped_pulse", 1, 1, 1, 0, 0, GREEN, RED, 0, 0);
        add("ped_pulse", 3, 1, 0, 0, 0, GREEN, RED, 0, 0);
        add("ped_pulse", 1, 1, 0, 0, 0, GREEN, RED, 0, 1);
        add("ped_pulse", 3, 1, 0, 0, 0, YELLOW, RED, 0, 0);
        add("ped_pulse", 1, 1, 0, 0, 0, RED, RED, 0, 0);
        add("ped_pulse", 5, 1, 0, 0, 0, RED, GREEN, 1, 0);
        add("ped_pulse", 1, 1, 0, 0, 0, RED, YELLOW, 0, 0);

        start("short_min");
        car_to_fw("short_min");
        add("short_min", 3, 1, 0, 0, 0, RED, GREEN, 0, 0);
        add("short_min", 1, 1, 0, 0, 0, RED, YELLOW, 0, 0);

        start("ped_in_fwg");
        car_to_fw("ped_in_fwg");
        add("ped_in_fwg", 1, 1, 0, 1, 0, RED, GREEN, 0, 0);
        add("ped_in_fwg", 1, 1, 0, 0, 0, RED, GREEN, 0, 0);
        add("ped_in_fwg", 1, 1, 0, 1, 0, RED, GREEN, 0, 0);
        add("ped_in_fwg", 3, 1, 0, 0, 0, RED, YELLOW, 0, 0);
        add("ped_in_fwg", 1, 1, 0, 0, 0, RED, RED, 0, 0);
        add("ped_in_fwg", 20, 1, 0, 0, 0, GREEN, RED, 0, 0);

        start("reset_mid");
        car_to_fw("reset_mid");
        add("reset_mid", 2, 1, 0, 0, 0, RED, GREEN, 0, 0);
        add("reset_mid", 1, 1, 0, 1, 1, RED, GREEN, 0, 0);
        add("reset_mid", 20, 1, 0, 0, 0, GREEN, RED, 0, 0);

        foreach (tab[i]) begin
            for (int k = 0; k < tab[i].n; k++) begin
                @(negedge clk);
                reset = tab[i].rst;
                car_on_fw = tab[i].car;
                ped_req = tab[i].ped;
                #1;
                if (tab[i].chk) begin
                    cmp({tab[i].tag, ".hw_light"}, int'(hw_light), int'(tab[i].hw));
                    cmp({tab[i].tag, ".fw_light"}, int'(fw_light), int'(tab[i].fw));
                    cmp({tab[i].tag, ".ped_walk"}, int'(ped_walk), int'(tab[i].walk));
                    cmp({tab[i].tag, ".hw_handover"}, int'(hw_handover), int'(tab[i].ho));
                end
            end
        end

        rc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) rc = ~rc;
            rp = ($urandom_range(0, 19) == 0);
            rr = (i == 0) || ($urandom_range(0, 299) == 0);
            reset = rr;
            car_on_fw = rc;
            ped_req = rp;
            #1;
            if (i > 0) begin
                cmp("rand.hw_light", int'(hw_light), hw_of[m_ph]);
                cmp("rand.fw_light", int'(fw_light), fw_of[m_ph]);
                cmp("rand.ped_walk", int'(ped_walk), int'(m_ph == 3 && m_mode));
                cmp("rand.hw_handover", int'(hw_handover),
                    int'(m_ph == 0 && m_t >= LONG - 1 && (rc || m_pend)));
            end
            m_step(rc, rp, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
